// File: rtl/aes_byteserial_ctrl.sv
// Control sequencer for a byte-serial AES-128 encryption datapath. It produces one encryption per start and takes 203 cycles from start to done.
// Define AES_CTRL_GUARDS_EN to drive the doSG/doCG guard strobes; otherwise both are held at 0.
module aes_byteserial_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       en,
   output logic       din_ready,
   output logic       sel_fb,
   output logic       key_en,
   output logic       doSR,
   output logic       doMC,
   output logic       doSG,
   output logic       doCG,
   output logic       last_round,
   output logic [3:0] round,
   output logic [3:0] byte_cnt,
   output logic [7:0] rcon,
   output logic       dout_valid,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ROUND = 3'd2,
      S_SR    = 3'd3,
      S_OUT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [3:0] cnt_n;
   logic [3:0] round_n;
   logic [7:0] rcon_n;
   logic       busy_n;
   logic       din_ready_n;
   logic       sel_fb_n;
   logic       key_en_n;
   logic       do_sr_n;
   logic       do_mc_n;
   logic       do_sg_n;
   logic       do_cg_n;
   logic       last_round_n;
   logic       dout_valid_n;
   logic       done_n;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   always_comb begin
      state_n = state;
      cnt_n   = byte_cnt + 4'd1;
      round_n = round;
      rcon_n  = rcon;
      case (state)
         S_IDLE: begin
            cnt_n   = 4'd0;
            round_n = 4'd0;
            rcon_n  = 8'h00;
            if (start) begin
               state_n = S_LOAD;
               rcon_n  = 8'h01;
            end
         end
         S_LOAD: begin
            if (byte_cnt == 4'd15) begin
               state_n = S_ROUND;
               cnt_n   = 4'd0;
               round_n = 4'd1;
            end
         end
         S_ROUND: begin
            if (byte_cnt == 4'd15) begin
               state_n = S_SR;
               cnt_n   = 4'd0;
            end
         end
         S_SR: begin
            cnt_n = 4'd0;
            if (round == 4'd10) begin
               state_n = S_OUT;
               round_n = 4'd0;
            end else begin
               state_n = S_ROUND;
               round_n = round + 4'd1;
               rcon_n  = xtime(rcon);
            end
         end
         S_OUT: begin
            if (byte_cnt == 4'd15) begin
               state_n = S_DONE;
               cnt_n   = 4'd0;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
            rcon_n  = 8'h00;
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
            round_n = 4'd0;
            rcon_n  = 8'h00;
         end
      endcase

      // Strobes are decoded from the next state so every output leaves a flop.
      busy_n       = (state_n == S_LOAD) || (state_n == S_ROUND) ||
                     (state_n == S_SR)   || (state_n == S_OUT);
      din_ready_n  = (state_n == S_LOAD);
      sel_fb_n     = (state_n == S_ROUND) || (state_n == S_SR);
      key_en_n     = (state_n == S_ROUND);
      do_sr_n      = (state_n == S_SR);
      do_mc_n      = (state_n == S_ROUND) && (round_n >= 4'd2) && (cnt_n[1:0] == 2'b00);
      last_round_n = (state_n == S_ROUND) && (round_n == 4'd10);
      dout_valid_n = (state_n == S_OUT);
      done_n       = (state_n == S_DONE);
`ifdef AES_CTRL_GUARDS_EN
      do_sg_n      = (state_n == S_ROUND) && (cnt_n == 4'd15);
      do_cg_n      = (state_n == S_SR) || ((state == S_SR) && (state_n == S_ROUND));
`else
      do_sg_n      = 1'b0;
      do_cg_n      = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_cnt   <= 4'd0;
         round      <= 4'd0;
         rcon       <= 8'h00;
         busy       <= 1'b0;
         din_ready  <= 1'b0;
         sel_fb     <= 1'b0;
         key_en     <= 1'b0;
         doSR       <= 1'b0;
         doMC       <= 1'b0;
         doSG       <= 1'b0;
         doCG       <= 1'b0;
         last_round <= 1'b0;
         dout_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         byte_cnt   <= cnt_n;
         round      <= round_n;
         rcon       <= rcon_n;
         busy       <= busy_n;
         din_ready  <= din_ready_n;
         sel_fb     <= sel_fb_n;
         key_en     <= key_en_n;
         doSR       <= do_sr_n;
         doMC       <= do_mc_n;
         doSG       <= do_sg_n;
         doCG       <= do_cg_n;
         last_round <= last_round_n;
         dout_valid <= dout_valid_n;
         done       <= done_n;
      end
   end

   assign en = busy;

endmodule

// File: tb/tb_aes_byteserial_ctrl.sv
// Bench for aes_byteserial_ctrl: schedule model, checkpoint table, and output/done scoreboard.
module tb_aes_byteserial_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy, en, din_ready, sel_fb, key_en, doSR, doMC, doSG, doCG, last_round;
   logic [3:0] round, byte_cnt;
   logic [7:0] rcon;
   logic       dout_valid, done;

   aes_byteserial_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .en(en),
      .din_ready(din_ready), .sel_fb(sel_fb), .key_en(key_en), .doSR(doSR),
      .doMC(doMC), .doSG(doSG), .doCG(doCG), .last_round(last_round),
      .round(round), .byte_cnt(byte_cnt), .rcon(rcon),
      .dout_valid(dout_valid), .done(done)
   );

   always #5 clk = ~clk;

`ifdef AES_CTRL_GUARDS_EN
   localparam bit G = 1'b1;
`else
   localparam bit G = 1'b0;
`endif

   typedef struct packed {
      logic       busy, en, din_ready, sel_fb, key_en, do_sr, do_mc, do_sg, do_cg, last_round, dout_valid, done;
      logic [3:0] round;
      logic [3:0] byte_cnt;
      logic [7:0] rcon;
   } outs_t;

   typedef struct {
      int    k;
      outs_t e;
   } vec_t;

   localparam int NV = 15;
   vec_t       tbl[NV];
   logic [7:0] rc_tab[10];

   int cyc = 0;
   int c0 = 0;
   bit mon_on = 1'b0;
   int abort_k = 0;
   bit hold = 1'b0;
   int n_chk = 0;
   int n_pass = 0;
   int q_out[$];
   int q_done[$];
   int n_sr, n_mc, first_mc, n_ke, n_sg, n_cg, n_done;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic outs_t sample();
      outs_t s;
      s = {busy, en, din_ready, sel_fb, key_en, doSR, doMC, doSG, doCG, last_round,
           dout_valid, done, round, byte_cnt, rcon};
      return s;
   endfunction

   function automatic outs_t o(input bit b, dr, sf, ke, sr, mc, sg, cg, lr, dv, dn,
                               input logic [3:0] rd, bc, input logic [7:0] rc);
      outs_t t;
      t = {b, b, dr, sf, ke, sr, mc, sg, cg, lr, dv, dn, rd, bc, rc};
      return t;
   endfunction

   // Expected outputs for relative cycle k, taken from the published cycle schedule.
   function automatic outs_t model(input int kin);
      outs_t e;
      int k, j, r, p;
      e = '0;
      k = kin;
      if (abort_k > 0 && k > abort_k) return e;
      if (hold) k = ((k - 1) % 204) + 1;
      if (k >= 1 && k <= 16) begin
         e.busy = 1; e.en = 1; e.din_ready = 1;
         e.byte_cnt = 4'(k - 1); e.rcon = 8'h01;
      end else if (k >= 17 && k <= 186) begin
         j = k - 17; r = j / 17 + 1; p = j % 17;
         e.busy = 1; e.en = 1; e.sel_fb = 1;
         e.round = 4'(r); e.rcon = rc_tab[r-1];
         if (p < 16) begin
            e.key_en = 1;
            e.byte_cnt = 4'(p);
            e.do_mc = (r >= 2) && (p % 4 == 0);
            e.last_round = (r == 10);
            e.do_sg = G && (p == 15);
            e.do_cg = G && (p == 0) && (r >= 2);
         end else begin
            e.do_sr = 1;
            e.do_cg = G;
         end
      end else if (k >= 187 && k <= 202) begin
         e.busy = 1; e.en = 1; e.dout_valid = 1;
         e.byte_cnt = 4'(k - 187); e.rcon = 8'h36;
      end else if (k == 203) begin
         e.done = 1; e.rcon = 8'h36;
      end
      return e;
   endfunction

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         int    k;
         int    x;
         outs_t g;
         outs_t e;
         k = cyc - c0 + 1;
         g = sample();
         e = model(k);
         check(g === e, $sformatf("outs_k%0d", k), 64'(g), 64'(e));
         if (g.do_sr) n_sr++;
         if (g.do_mc) begin
            if (n_mc == 0) first_mc = k;
            n_mc++;
         end
         if (g.key_en) n_ke++;
         if (g.do_sg) n_sg++;
         if (g.do_cg) n_cg++;
         if (g.dout_valid) begin
            if (q_out.size() == 0) check(1'b0, "dout_unexpected", 64'(k), 64'(0));
            else begin
               x = q_out.pop_front();
               check(x == k, "dout_cycle", 64'(k), 64'(x));
            end
         end
         if (g.done) begin
            n_done++;
            if (q_done.size() == 0) check(1'b0, "done_unexpected", 64'(k), 64'(0));
            else begin
               x = q_done.pop_front();
               check(x == k, "done_cycle", 64'(k), 64'(x));
            end
         end
      end
   end

   task automatic run(input int ab, input bit hd, input int last_k, input int nruns, input bit use_tbl);
      int ti;
      int k;
      n_sr = 0; n_mc = 0; first_mc = 0; n_ke = 0; n_sg = 0; n_cg = 0; n_done = 0;
      abort_k = ab; hold = hd; ti = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int n = 0; n < nruns; n++) begin
         for (int i = 0; i < 16; i++) q_out.push_back(187 + i + 204 * n);
         q_done.push_back(203 + 204 * n);
      end
      mon_on = 1'b1;
      if (!hd) start = 1'b0;
      do begin
         @(negedge clk);
         k = cyc - c0 + 1;
         if (use_tbl && ti < NV && k == tbl[ti].k) begin
            check(sample() === tbl[ti].e, $sformatf("table_k%0d", k), 64'(sample()), 64'(tbl[ti].e));
            ti++;
         end
         if (ab > 0 && k == ab) rst = 1'b1;
         if (ab > 0 && k == ab + 1) rst = 1'b0;
         if (hd && k == 300) start = 1'b0;
      end while (k < last_k);
      #1;
      mon_on = 1'b0;
      if (use_tbl) check(ti == NV, "table_coverage", 64'(ti), 64'(NV));
      check(q_out.size() == 0, "dout_missing", 64'(q_out.size()), 64'(0));
      check(q_done.size() == 0, "done_missing", 64'(q_done.size()), 64'(0));
      q_out.delete();
      q_done.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   initial begin
      rc_tab[0] = 8'h01; rc_tab[1] = 8'h02; rc_tab[2] = 8'h04; rc_tab[3] = 8'h08; rc_tab[4] = 8'h10;
      rc_tab[5] = 8'h20; rc_tab[6] = 8'h40; rc_tab[7] = 8'h80; rc_tab[8] = 8'h1B; rc_tab[9] = 8'h36;

      //                 b  dr sf ke sr mc sg cg lr dv dn  rd     bc      rcon
      tbl[0]  = '{1,   o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  4'd0,  8'h01)};
      tbl[1]  = '{16,  o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  4'd15, 8'h01)};
      tbl[2]  = '{17,  o(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'd1,  4'd0,  8'h01)};
      tbl[3]  = '{32,  o(1, 0, 1, 1, 0, 0, G, 0, 0, 0, 0, 4'd1,  4'd15, 8'h01)};
      tbl[4]  = '{33,  o(1, 0, 1, 0, 1, 0, 0, G, 0, 0, 0, 4'd1,  4'd0,  8'h01)};
      tbl[5]  = '{34,  o(1, 0, 1, 1, 0, 1, 0, G, 0, 0, 0, 4'd2,  4'd0,  8'h02)};
      tbl[6]  = '{38,  o(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd2,  4'd4,  8'h02)};
      tbl[7]  = '{153, o(1, 0, 1, 1, 0, 1, 0, G, 0, 0, 0, 4'd9,  4'd0,  8'h1B)};
      tbl[8]  = '{170, o(1, 0, 1, 1, 0, 1, 0, G, 1, 0, 0, 4'd10, 4'd0,  8'h36)};
      tbl[9]  = '{185, o(1, 0, 1, 1, 0, 0, G, 0, 1, 0, 0, 4'd10, 4'd15, 8'h36)};
      tbl[10] = '{186, o(1, 0, 1, 0, 1, 0, 0, G, 0, 0, 0, 4'd10, 4'd0,  8'h36)};
      tbl[11] = '{187, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd0,  8'h36)};
      tbl[12] = '{202, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd15, 8'h36)};
      tbl[13] = '{203, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0,  4'd0,  8'h36)};
      tbl[14] = '{204, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0,  4'd0,  8'h00)};

      // Reset held with start high: everything stays zero and no LOAD follows.
      rst = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check(sample() === outs_t'(0), "reset_outputs", 64'(sample()), 64'(0));
      end
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check(sample() === outs_t'(0), "idle_after_reset", 64'(sample()), 64'(0));

      // Full run with checkpoint table and strobe totals.
      run(0, 1'b0, 215, 1, 1'b1);
      check(n_sr == 10, "dosr_count", 64'(n_sr), 64'(10));
      check(n_mc == 36, "domc_count", 64'(n_mc), 64'(36));
      check(first_mc == 34, "domc_first", 64'(first_mc), 64'(34));
      check(n_ke == 160, "key_en_count", 64'(n_ke), 64'(160));
      check(n_sg == (G ? 10 : 0), "dosg_count", 64'(n_sg), 64'(G ? 10 : 0));
      check(n_cg == (G ? 19 : 0), "docg_count", 64'(n_cg), 64'(G ? 19 : 0));
      check(n_done == 1, "done_count", 64'(n_done), 64'(1));

      // Abort with reset at cycle 100: no output bytes, no done.
      run(100, 1'b0, 230, 0, 1'b0);
      check(n_done == 0, "abort_no_done", 64'(n_done), 64'(0));

      // A fresh start after the abort completes normally.
      run(0, 1'b0, 215, 1, 1'b0);
      check(n_done == 1, "rerun_done_count", 64'(n_done), 64'(1));
      check(n_sr == 10, "rerun_dosr_count", 64'(n_sr), 64'(10));

      // start held high: the pulse seen in DONE is ignored and the second LOAD begins at cycle 205.
      run(0, 1'b1, 408, 2, 1'b0);
      check(n_done == 2, "held_done_count", 64'(n_done), 64'(2));
      check(n_mc == 72, "held_domc_count", 64'(n_mc), 64'(72));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
